version_disp_decode_xt: RTL and testbench

- Reads the XT receiver-board LD1/LD2 LED drive and recovers what the board is signalling.
- Recovers the 8-bit version shown after configuration done, the IM-download-OK double blink, and the IM-download-error alternating blink.
- Sits on the tester/monitor side of the LED lines and shares the board's frame_alt tick source.
- Reports each decoded result as a one-clock pulse.

---
 rtl/version_disp_decode_xt_pkg.sv | 34 +++
 rtl/version_disp_decode_xt_led_pulse_meter.sv | 101 ++++++++++
 rtl/version_disp_decode_xt.sv | 181 ++++++++++++++++++
 tb/tb_version_disp_decode_xt.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/version_disp_decode_xt_pkg.sv
// Shared definitions for the XT LED-protocol decoder: symbols, FSM states, tick defaults.
package version_disp_decode_xt_pkg;

   localparam int unsigned HALF_TICKS_DEF = 12;
   localparam int unsigned TOL_DEF        = 2;
   localparam int unsigned GAP_TICKS_DEF  = 30;
   localparam int unsigned CNT_W_DEF      = 6;

   localparam int unsigned SYM_W     = 2;
   localparam int unsigned MAX_SYMS  = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned SYM_CNT_W = 4;
   localparam int unsigned VER_W     = 8;

   typedef enum logic [SYM_W-1:0] {
      SYM_NONE = 2'd0,
      SYM_L1   = 2'd1,
      SYM_L2   = 2'd2,
      SYM_BOTH = 2'd3
   } sym_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LIT     = 2'd1,
      ST_DARK    = 2'd2,
      ST_DISCARD = 2'd3
   } state_e;

   // A version bit is carried by LD1 alone (0) or both LEDs (1).
   function automatic logic is_ver_sym(input logic [SYM_W-1:0] s);
      return (s == SYM_L1) || (s == SYM_BOTH);
   endfunction

endpackage

// File: rtl/version_disp_decode_xt_led_pulse_meter.sv
// Synchronises the LED lines and frame tick, measures lit-pulse width and dark gap,
// and presents one symbol per lit pulse on the lit falling edge.
module version_disp_decode_xt_led_pulse_meter
   import version_disp_decode_xt_pkg::*;
#(
   parameter int unsigned HALF_TICKS = HALF_TICKS_DEF,
   parameter int unsigned TOL        = TOL_DEF,
   parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_frame_alt,
   input  logic             i_ld1_on,
   input  logic             i_ld2_on,
   output logic             o_lit_rise_c,
   output logic             o_sym_vld_c,
   output logic [SYM_W-1:0] o_sym_c,
   output logic             o_width_ok_c,
   output logic             o_width_over_c,
   output logic             o_gap_done_c
);

   localparam logic [CNT_W-1:0] L_LO  = CNT_W'(HALF_TICKS - TOL);
   localparam logic [CNT_W-1:0] L_HI  = CNT_W'(HALF_TICKS + TOL);
   localparam logic [CNT_W-1:0] L_GAP = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0] L_MAX = '1;

   logic [1:0]       r_fa_sync;
   logic [1:0]       r_ld1_sync;
   logic [1:0]       r_ld2_sync;
   logic             r_fa_d;
   logic             r_lit_d;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_gap;
   logic [SYM_W-1:0] r_seen;

   logic             w_tick;
   logic             w_lit;
   logic             w_rise;
   logic             w_fall;
   logic [SYM_W-1:0] w_leds;

   assign w_tick = r_fa_sync[1] ^ r_fa_d;
   assign w_leds = {r_ld2_sync[1], r_ld1_sync[1]};
   assign w_lit  = |w_leds;
   assign w_rise = w_lit & ~r_lit_d;
   assign w_fall = ~w_lit & r_lit_d;

   // Two-flop synchronisers and edge-history flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fa_sync  <= '0;
         r_ld1_sync <= '0;
         r_ld2_sync <= '0;
         r_fa_d     <= 1'b0;
         r_lit_d    <= 1'b0;
      end else begin
         r_fa_sync  <= {r_fa_sync[0], i_frame_alt};
         r_ld1_sync <= {r_ld1_sync[0], i_ld1_on};
         r_ld2_sync <= {r_ld2_sync[0], i_ld2_on};
         r_fa_d     <= r_fa_sync[1];
         r_lit_d    <= w_lit;
      end
   end

   // Lit width in ticks and which LEDs were seen during the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_width <= '0;
         r_seen  <= '0;
      end else if (w_rise) begin
         r_width <= CNT_W'(w_tick);
         r_seen  <= w_leds;
      end else if (w_lit) begin
         r_seen  <= r_seen | w_leds;
         if (w_tick && (r_width != L_MAX)) begin
            r_width <= r_width + CNT_W'(1);
         end
      end
   end

   // Continuous dark ticks, saturating at the group-end threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else if (w_lit) begin
         r_gap <= '0;
      end else if (w_tick && (r_gap != L_GAP)) begin
         r_gap <= r_gap + CNT_W'(1);
      end
   end

   assign o_lit_rise_c   = w_rise;
   assign o_sym_vld_c    = w_fall;
   assign o_sym_c        = r_seen;
   assign o_width_ok_c   = (r_width >= L_LO) && (r_width <= L_HI);
   assign o_width_over_c = (r_width > L_HI);
   assign o_gap_done_c   = ~w_lit && (r_gap == L_GAP);

endmodule

// File: rtl/version_disp_decode_xt.sv
// Decodes the XT receiver-board LED protocol into version, download-OK and
// download-error pulses; holds the group FSM and symbol buffer.
module version_disp_decode_xt
   import version_disp_decode_xt_pkg::*;
#(
   parameter int unsigned HALF_TICKS = HALF_TICKS_DEF,
   parameter int unsigned TOL        = TOL_DEF,
   parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_alt,
   input  logic             ld1_on,
   input  logic             ld2_on,
   output logic [VER_W-1:0] ver_out,
   output logic             ver_valid,
   output logic             dl_ok,
   output logic             dl_err,
   output logic             frame_err,
   output logic             busy
);

   logic                              w_lit_rise;
   logic                              w_sym_vld;
   logic [SYM_W-1:0]                  w_sym;
   logic                              w_width_ok;
   logic                              w_width_over;
   logic                              w_gap_done;

   state_e                            r_state;
   logic [MAX_SYMS-1:0][SYM_W-1:0]    r_buf;
   logic [SYM_CNT_W-1:0]              r_cnt;
   logic                              r_quad;
   logic [VER_W-1:0]                  r_ver;
   logic                              r_ver_valid;
   logic                              r_dl_ok;
   logic                              r_dl_err;
   logic                              r_frame_err;
   logic                              r_busy;

   logic [IDX_W-1:0]                  w_idx;
   logic                              w_full;
   logic                              w_l2_ok;
   logic                              w_quad_done;
   logic                              w_sym_bad;
   logic [VER_W-1:0]                  w_ver;
   logic                              w_all_ver;
   logic                              w_is_ver;
   logic                              w_is_ok;
   logic                              w_is_quads;

   version_disp_decode_xt_led_pulse_meter #(
      .HALF_TICKS (HALF_TICKS),
      .TOL        (TOL),
      .GAP_TICKS  (GAP_TICKS),
      .CNT_W      (CNT_W)
   ) u_meter (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_frame_alt    (frame_alt),
      .i_ld1_on       (ld1_on),
      .i_ld2_on       (ld2_on),
      .o_lit_rise_c   (w_lit_rise),
      .o_sym_vld_c    (w_sym_vld),
      .o_sym_c        (w_sym),
      .o_width_ok_c   (w_width_ok),
      .o_width_over_c (w_width_over),
      .o_gap_done_c   (w_gap_done)
   );

   assign w_idx  = r_cnt[IDX_W-1:0];
   assign w_full = (r_cnt == SYM_CNT_W'(MAX_SYMS));

   // An LD2-only symbol is legal only where it continues an L1,L1,L2,L2 quad.
   assign w_l2_ok = ((r_cnt == SYM_CNT_W'(2)) && (r_buf[0] == SYM_L1) && (r_buf[1] == SYM_L1)) ||
                    ((r_cnt == SYM_CNT_W'(3)) && (r_buf[0] == SYM_L1) && (r_buf[1] == SYM_L1) &&
                     (r_buf[2] == SYM_L2));
   assign w_quad_done = (r_cnt == SYM_CNT_W'(3)) && (w_sym == SYM_L2) && w_l2_ok;
   assign w_sym_bad   = !w_width_ok || w_full || ((w_sym == SYM_L2) && !w_l2_ok);

   // Version assembly: symbol 0 is the MSB, BOTH means a 1 bit.
   always_comb begin
      w_ver     = '0;
      w_all_ver = 1'b1;
      for (int i = 0; i < MAX_SYMS; i++) begin
         w_ver[VER_W-1-i] = (r_buf[i] == SYM_BOTH);
         w_all_ver        = w_all_ver & is_ver_sym(r_buf[i]);
      end
   end

   assign w_is_ver   = w_full && w_all_ver;
   assign w_is_ok    = (r_cnt == SYM_CNT_W'(2)) && (r_buf[0] == SYM_BOTH) && (r_buf[1] == SYM_BOTH);
   assign w_is_quads = (r_cnt == '0) && r_quad;

   // Group FSM with symbol buffer and registered result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_buf       <= '0;
         r_cnt       <= '0;
         r_quad      <= 1'b0;
         r_ver       <= '0;
         r_ver_valid <= 1'b0;
         r_dl_ok     <= 1'b0;
         r_dl_err    <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_ver_valid <= 1'b0;
         r_dl_ok     <= 1'b0;
         r_dl_err    <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_lit_rise) begin
                  r_state <= ST_LIT;
                  r_busy  <= 1'b1;
                  r_buf   <= '0;
                  r_cnt   <= '0;
                  r_quad  <= 1'b0;
               end
            end
            ST_LIT: begin
               if (w_width_over) begin
                  r_frame_err <= 1'b1;
                  r_state     <= ST_DISCARD;
               end else if (w_sym_vld) begin
                  if (w_sym_bad) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_DISCARD;
                  end else if (w_quad_done) begin
                     r_dl_err <= 1'b1;
                     r_cnt    <= '0;
                     r_quad   <= 1'b1;
                     r_state  <= ST_DARK;
                  end else begin
                     r_buf[w_idx] <= w_sym;
                     r_cnt        <= r_cnt + SYM_CNT_W'(1);
                     r_state      <= ST_DARK;
                  end
               end
            end
            ST_DARK: begin
               if (w_lit_rise) begin
                  r_state <= ST_LIT;
               end else if (w_gap_done) begin
                  if (w_is_ver) begin
                     r_ver       <= w_ver;
                     r_ver_valid <= 1'b1;
                  end else if (w_is_ok) begin
                     r_dl_ok <= 1'b1;
                  end else if (!w_is_quads) begin
                     r_frame_err <= 1'b1;
                  end
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_DISCARD: begin
               if (w_gap_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ver_out   = r_ver;
   assign ver_valid = r_ver_valid;
   assign dl_ok     = r_dl_ok;
   assign dl_err    = r_dl_err;
   assign frame_err = r_frame_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_version_disp_decode_xt.sv
// Bench for version_disp_decode_xt: directed LED groups, protocol-level model,
// per-cycle comparison of result pulses, latency and held version.
module tb_version_disp_decode_xt;

   localparam int K_VER  = 1;
   localparam int K_OK   = 2;
   localparam int K_ERR  = 3;
   localparam int K_FERR = 4;
   localparam int LAT_ANY  = 0;
   localparam int LAT_FALL = 1;
   localparam int LAT_GAP  = 2;
   localparam int W_LO = 10;
   localparam int W_HI = 14;

   typedef struct {
      int         kind;
      logic [7:0] ver;
      int         lat;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_alt;
   logic       ld1_on;
   logic       ld2_on;
   logic [7:0] ver_out;
   logic       ver_valid;
   logic       dl_ok;
   logic       dl_err;
   logic       frame_err;
   logic       busy;

   ev_t        exp_q[$];
   logic [1:0] g_leds[$];
   int         g_w[$];
   logic [7:0] exp_ver = 8'h00;
   int         cyc = 0;
   int         last_fall = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   version_disp_decode_xt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_alt (frame_alt),
      .ld1_on    (ld1_on),
      .ld2_on    (ld2_on),
      .ver_out   (ver_out),
      .ver_valid (ver_valid),
      .dl_ok     (dl_ok),
      .dl_err    (dl_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
   endtask

   task automatic push_ev(input int k, input logic [7:0] v, input int l);
      ev_t e;
      e.kind = k;
      e.ver  = v;
      e.lat  = l;
      exp_q.push_back(e);
   endtask

   // Protocol model: walks the queued pulses of one group and predicts the result pulses.
   task automatic model_group();
      logic [1:0] syms[$];
      int         quad_pat[4];
      bit         quad_seen;
      bit         prefix_ok;
      logic [7:0] v;
      bit         all_ver;
      quad_pat  = '{1, 1, 2, 2};
      quad_seen = 1'b0;
      for (int i = 0; i < g_w.size(); i++) begin
         if (g_w[i] > W_HI) begin push_ev(K_FERR, 8'h00, LAT_ANY); return; end
         if (g_w[i] < W_LO) begin push_ev(K_FERR, 8'h00, LAT_FALL); return; end
         if (syms.size() == 8) begin push_ev(K_FERR, 8'h00, LAT_FALL); return; end
         if (g_leds[i] == 2'b10) begin
            prefix_ok = (syms.size() < 4);
            for (int j = 0; j < syms.size() && j < 4; j++)
               if (int'(syms[j]) != quad_pat[j]) prefix_ok = 1'b0;
            if (syms.size() < 4 && quad_pat[syms.size()] != 2) prefix_ok = 1'b0;
            if (!prefix_ok) begin push_ev(K_FERR, 8'h00, LAT_FALL); return; end
         end
         syms.push_back(g_leds[i]);
         if (syms.size() == 4 && syms[0] == 2'b01 && syms[1] == 2'b01 &&
             syms[2] == 2'b10 && syms[3] == 2'b10) begin
            push_ev(K_ERR, 8'h00, LAT_FALL);
            syms.delete();
            quad_seen = 1'b1;
         end
      end
      all_ver = 1'b1;
      v = 8'h00;
      foreach (syms[i]) begin
         if (syms[i] != 2'b01 && syms[i] != 2'b11) all_ver = 1'b0;
         if (i < 8 && syms[i] == 2'b11) v[7-i] = 1'b1;
      end
      if (syms.size() == 8 && all_ver)                            push_ev(K_VER, v, LAT_GAP);
      else if (syms.size() == 2 && syms[0] == 2'b11 && syms[1] == 2'b11) push_ev(K_OK, 8'h00, LAT_GAP);
      else if (!(syms.size() == 0 && quad_seen))                  push_ev(K_FERR, 8'h00, LAT_GAP);
   endtask

   task automatic wait_tick();
      repeat (2) @(negedge clk);
      frame_alt = ~frame_alt;
      repeat (2) @(negedge clk);
   endtask

   task automatic dark(input int n);
      repeat (n) wait_tick();
   endtask

   task automatic pulse(input logic [1:0] leds, input int w);
      ld1_on = leds[0];
      ld2_on = leds[1];
      repeat (w) wait_tick();
      ld1_on = 1'b0;
      ld2_on = 1'b0;
      last_fall = cyc;
   endtask

   task automatic add_pulse(input logic [1:0] leds, input int w);
      g_leds.push_back(leds);
      g_w.push_back(w);
   endtask

   task automatic add_ver(input logic [7:0] v);
      for (int i = 0; i < 8; i++) add_pulse(v[7-i] ? 2'b11 : 2'b01, 12);
   endtask

   task automatic add_quads(input int n);
      for (int i = 0; i < n; i++) begin
         add_pulse(2'b01, 12); add_pulse(2'b01, 12);
         add_pulse(2'b10, 12); add_pulse(2'b10, 12);
      end
   endtask

   // Drives the queued group (model already run), then a long dark tail.
   task automatic send_group(input int tail);
      for (int i = 0; i < g_w.size(); i++) begin
         pulse(g_leds[i], g_w[i]);
         if (i != g_w.size() - 1) dark(12);
      end
      g_leds.delete();
      g_w.delete();
      dark(tail);
      chk("all_expected_pulses_seen", exp_q.size(), 0);
      chk("idle_after_group", int'(busy), 0);
   endtask

   // Compare process: every result pulse must match the model's next event.
   always @(negedge clk) begin
      int  np;
      int  kind;
      int  d;
      int  lo;
      int  hi;
      ev_t e;
      if (!rst_n) begin
         chk("reset_outputs", int'({ver_out, ver_valid, dl_ok, dl_err, frame_err, busy}), 0);
         exp_ver = 8'h00;
      end else begin
         np = int'(ver_valid) + int'(dl_ok) + int'(dl_err) + int'(frame_err);
         if (np != 0) begin
            kind = ver_valid ? K_VER : dl_ok ? K_OK : dl_err ? K_ERR : K_FERR;
            chk("single_pulse", np, 1);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse_kind", kind, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", kind, e.kind);
               if (e.kind == K_VER) begin
                  chk("ver_value", int'(ver_out), int'(e.ver));
                  exp_ver = e.ver;
               end
               if (e.lat != LAT_ANY) begin
                  d  = cyc - last_fall;
                  lo = (e.lat == LAT_FALL) ? 2 : 120;
                  hi = (e.lat == LAT_FALL) ? 4 : 124;
                  n_chk++;
                  if (d >= lo && d <= hi) n_pass++;
                  else $display("FAIL pulse_latency: got %0d clks want %0d..%0d", d, lo, hi);
               end
            end
         end
         chk("ver_hold", int'(ver_out), int'(exp_ver));
      end
   end

   initial begin
      rst_n = 1'b1;
      frame_alt = 1'b0;
      ld1_on = 1'b0;
      ld2_on = 1'b0;
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b1;
      dark(4);

      // Version 0xA5; pin the model with the hand-derived value.
      add_ver(8'hA5);
      model_group();
      chk("pin_a5_count", exp_q.size(), 1);
      chk("pin_a5_kind", exp_q[0].kind, K_VER);
      chk("pin_a5_value", int'(exp_q[0].ver), 'hA5);
      send_group(40);

      // Download OK: two BOTH pulses.
      add_pulse(2'b11, 12); add_pulse(2'b11, 12);
      model_group();
      chk("pin_ok_kind", exp_q[0].kind, K_OK);
      chk("pin_ok_lat", exp_q[0].lat, LAT_GAP);
      send_group(40);

      // Three error quads, then eight back-to-back quads.
      add_quads(3);
      model_group();
      chk("pin_3quad_count", exp_q.size(), 3);
      chk("pin_3quad_kind", exp_q[2].kind, K_ERR);
      send_group(40);
      add_quads(8);
      model_group();
      chk("pin_8quad_count", exp_q.size(), 8);
      send_group(40);

      // Over-long pulse: frame_err, busy through the discard gap.
      add_pulse(2'b01, 16);
      model_group();
      chk("pin_long_kind", exp_q[0].kind, K_FERR);
      pulse(2'b01, 16);
      g_leds.delete();
      g_w.delete();
      dark(28);
      chk("busy_in_discard", int'(busy), 1);
      dark(4);
      chk("idle_after_discard", int'(busy), 0);
      chk("long_pulse_err_seen", exp_q.size(), 0);
      add_ver(8'h3C);
      model_group();
      chk("pin_3c_value", int'(exp_q[0].ver), 'h3C);
      send_group(40);

      // Width boundaries: 10 and 14 accepted, 9 and 15 rejected.
      for (int i = 0; i < 8; i++) add_pulse((i == 0 || i == 3 || i == 5 || i == 6) ? 2'b11 : 2'b01,
                                            (i % 2 == 0) ? 10 : 14);
      model_group();
      chk("pin_96_value", int'(exp_q[0].ver), 'h96);
      send_group(40);
      add_pulse(2'b01, 9);
      model_group();
      chk("pin_w9_lat", exp_q[0].lat, LAT_FALL);
      send_group(40);
      add_pulse(2'b11, 15);
      model_group();
      send_group(40);

      // Five BOTH pulses, then nine L1 pulses.
      for (int i = 0; i < 5; i++) add_pulse(2'b11, 12);
      model_group();
      chk("pin_5both_lat", exp_q[0].lat, LAT_GAP);
      send_group(40);
      for (int i = 0; i < 9; i++) add_pulse(2'b01, 12);
      model_group();
      chk("pin_9l1_kind", exp_q[0].kind, K_FERR);
      chk("pin_9l1_lat", exp_q[0].lat, LAT_FALL);
      send_group(40);

      // An L2 that breaks the quad pattern.
      add_pulse(2'b01, 12); add_pulse(2'b10, 12);
      model_group();
      chk("pin_badl2_kind", exp_q[0].kind, K_FERR);
      send_group(40);

      // Reset in the middle of a version group, then 0x81.
      for (int i = 0; i < 4; i++) begin
         pulse(2'b11, 12);
         dark(12);
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b1;
      dark(40);
      chk("idle_after_mid_reset", int'(busy), 0);
      add_ver(8'h81);
      model_group();
      send_group(40);
      chk("final_ver_out", int'(ver_out), 'h81);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
